// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma encode datapath.
// Contents:
//   letter_t              - 5-bit letter code, 0=A .. 25=Z
//   LETTER_MAX            - highest legal letter code (Z)
//   SETTLE_CYCLES_DEFAULT - default rotor settle time in cycles
//   SETTLE_W              - width of the settle down-counter (holds 0..15)
//   seq_state_t           - keystroke sequencer FSM states
package enigma_pkg;

    typedef logic [4:0] letter_t;

    localparam letter_t LETTER_MAX            = 5'd25;
    localparam int      SETTLE_CYCLES_DEFAULT = 2;
    localparam int      SETTLE_W              = 4;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        SETTLE,
        START,
        WAIT,
        OUT
    } seq_state_t;

endpackage

// File: rtl/keystroke_sequencer_settle_timer.sv
// settle_timer: loadable down-counter with a done flag. It gives the rotor
// block time to settle after a step pulse.
// Ports:
//   clock      - system clock
//   reset      - synchronous, active-high reset (clears the count)
//   load       - load load_value into the counter
//   load_value - start value; done rises after load_value decrements
//   dec        - decrement request; ignored once the count reaches zero
//   done       - count is zero
module settle_timer
    import enigma_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_value,
    input  logic                dec,
    output logic                done
);

    logic [SETTLE_W-1:0] count;

    // Load takes priority over decrement. The count saturates at zero, so the
    // owner can hold dec high while it waits for done.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/keystroke_sequencer.sv
// keystroke_sequencer: per-keystroke controller for the Enigma encode path.
// It accepts one plaintext letter, pulses rotate so the rotors step, waits for
// the rotors to settle, launches the encode path, and then returns the
// ciphertext over a valid/ready handshake.
// Optional feature macro: KEY_RANGE_CHECK_EN. When it is defined, a letter
// above Z is consumed without being encoded and sets the sticky range_err flag.
// Ports:
//   clock, reset               - clock, synchronous active-high reset
//   key_valid/key_char/key_ready - plaintext letter handshake
//   config_mode                - settings editing; new keystrokes are blocked
//   rotate                     - rotor step request (the rotor steps on 0->1)
//   path_start/path_char       - one-cycle launch and letter for encode path
//   path_valid/path_result     - encode path result
//   cipher_valid/cipher_char/cipher_ready - ciphertext handshake
//   busy                       - high in every state except IDLE
//   char_count                 - completed ciphertext handshakes (wraps)
//   range_err                  - sticky illegal-letter flag
module keystroke_sequencer
    import enigma_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
    parameter int COUNT_W       = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [4:0]         key_char,
    output logic               key_ready,
    input  logic               config_mode,
    output logic               rotate,
    output logic               path_start,
    output logic [4:0]         path_char,
    input  logic               path_valid,
    input  logic [4:0]         path_result,
    output logic               cipher_valid,
    output logic [4:0]         cipher_char,
    input  logic               cipher_ready,
    output logic               busy,
    output logic [COUNT_W-1:0] char_count,
    output logic               range_err
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    seq_state_t state;
    logic       key_take;
    logic       key_bad;
    logic       timer_done;

    assign key_ready = (state == IDLE) && !config_mode;
    assign key_take  = key_valid && key_ready;
    assign busy      = (state != IDLE);

`ifdef KEY_RANGE_CHECK_EN
    assign key_bad = (key_char > LETTER_MAX);

    // A rejected letter is still consumed by the handshake. It only leaves
    // this flag behind, and the flag stays set until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            range_err <= 1'b0;
        end else if (key_take && key_bad) begin
            range_err <= 1'b1;
        end
    end
`else
    assign key_bad   = 1'b0;
    assign range_err = 1'b0;
`endif

    // The timer loads while rotate is high in STEP. It counts down through
    // SETTLE, so rotate stays low for SETTLE_CYCLES cycles before the path
    // starts.
    settle_timer u_settle_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (state == STEP),
        .load_value (SETTLE_LOAD),
        .dec        (state == SETTLE),
        .done       (timer_done)
    );

    // Main sequencing FSM. rotate and path_start are one-cycle pulses: they
    // default low every cycle and are set on the transition into STEP and
    // START. cipher_valid is held from the WAIT->OUT transition until the
    // consumer takes the letter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            rotate       <= 1'b0;
            path_start   <= 1'b0;
            path_char    <= '0;
            cipher_valid <= 1'b0;
            cipher_char  <= '0;
            char_count   <= '0;
        end else begin
            rotate     <= 1'b0;
            path_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_take && !key_bad) begin
                        path_char <= key_char;
                        rotate    <= 1'b1;
                        state     <= STEP;
                    end
                end
                STEP: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (timer_done) begin
                        path_start <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (path_valid) begin
                        cipher_char  <= path_result;
                        cipher_valid <= 1'b1;
                        state        <= OUT;
                    end
                end
                OUT: begin
                    if (cipher_ready) begin
                        cipher_valid <= 1'b0;
                        char_count   <= char_count + 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keystroke_sequencer.sv
// Testbench for keystroke_sequencer. A behavioural encode path answers every
// path_start one cycle later with (letter + 13) mod 26. The bench pushes the
// expected ciphertext onto a queue when it offers a letter, and pops the queue
// when a cipher handshake is observed.
module tb_keystroke_sequencer;

    localparam int SETTLE = 2;
    localparam int CW     = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          key_valid;
    logic [4:0]    key_char;
    logic          key_ready;
    logic          config_mode;
    logic          rotate;
    logic          path_start;
    logic [4:0]    path_char;
    logic          path_valid;
    logic [4:0]    path_result;
    logic          cipher_valid;
    logic [4:0]    cipher_char;
    logic          cipher_ready;
    logic          busy;
    logic [CW-1:0] char_count;
    logic          range_err;

    int          total = 0;
    int          bad   = 0;
    logic [4:0]  expQ[$];
    int          rotEdges = 0;
    int          lowRun   = 0;
    bit          rotSeen  = 0;
    bit          rotPrev  = 0;
    bit          respEn   = 1;
    bit          manualPv = 0;
    bit          startSeen = 0;
    logic [4:0]  charSeen  = '0;

    keystroke_sequencer #(.SETTLE_CYCLES(SETTLE), .COUNT_W(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_char     (key_char),
        .key_ready    (key_ready),
        .config_mode  (config_mode),
        .rotate       (rotate),
        .path_start   (path_start),
        .path_char    (path_char),
        .path_valid   (path_valid),
        .path_result  (path_result),
        .cipher_valid (cipher_valid),
        .cipher_char  (cipher_char),
        .cipher_ready (cipher_ready),
        .busy         (busy),
        .char_count   (char_count),
        .range_err    (range_err)
    );

    // Free-running clock with a 10 ns period.
    always #5 clock = ~clock;

    // Reference encode function used by both the path model and the
    // scoreboard.
    function automatic logic [4:0] encodeRef(input logic [4:0] c);
        int v;
        v = (int'(c) + 13) % 26;
        return 5'(v);
    endfunction

    // The only comparison point: it counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advances one clock and then lands 1 ns past the edge, where the bench
    // samples outputs and drives inputs.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic waitKeyReady(input string tag);
        int n = 0;
        while (!key_ready && n < 60) begin
            tick();
            n++;
        end
        if (!key_ready) checkOutput(tag, 0, 1);
    endtask

    // Offers one letter for a single cycle. The expected ciphertext is queued
    // only when the letter is supposed to be encoded.
    task automatic applyStimulus(input logic [4:0] c, input bit encodes);
        waitKeyReady("tmo_key_ready");
        key_valid = 1'b1;
        key_char  = c;
        if (encodes) expQ.push_back(encodeRef(c));
        tick();
        key_valid = 1'b0;
    endtask

    task automatic waitCount(input string tag, input int target);
        int n = 0;
        while (char_count != CW'(target) && n < 60) begin
            tick();
            n++;
        end
        checkOutput(tag, char_count, target);
    endtask

    // Encode-path model. A path_start seen in cycle k produces path_valid in
    // cycle k+1, with the result for the letter presented alongside path_start.
    // manualPv lets a test inject a stray path_valid.
    initial begin
        path_valid  = 1'b0;
        path_result = '0;
        forever begin
            @(posedge clock);
            #1;
            path_valid  = (respEn && startSeen) || manualPv;
            path_result = encodeRef(charSeen);
            startSeen   = path_start;
            charSeen    = path_char;
        end
    end

    // Monitor. It counts rotate rising edges and checks the low gap between
    // steps. It also checks each cipher handshake against the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (rotate) begin
                if (!rotPrev) begin
                    rotEdges++;
                    if (rotSeen) checkOutput("rot_gap_ok", lowRun >= SETTLE, 1);
                    rotSeen = 1;
                end
                lowRun = 0;
            end else begin
                lowRun++;
            end
            rotPrev = rotate;
            if (!reset && cipher_valid && cipher_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("sb_unexpected", 1, 0);
                end else begin
                    checkOutput("sb_cipher", cipher_char, expQ.pop_front());
                end
            end
        end
    end

    // Watchdog, so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0;
        reset        = 1'b1;
        key_valid    = 1'b0;
        key_char     = '0;
        config_mode  = 1'b0;
        cipher_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rotate", rotate, 0);
        checkOutput("rst_path_start", path_start, 0);
        checkOutput("rst_cipher_valid", cipher_valid, 0);
        checkOutput("rst_count", char_count, 0);
        checkOutput("rst_range_err", range_err, 0);
        checkOutput("rst_key_ready", key_ready, 1);

        // Latency for a single key 'A': rotate at T+1, path_start at T+4,
        // cipher_valid at T+6 (k counts cycles after acceptance).
        applyStimulus(5'd0, 1);
        for (int k = 1; k <= 8; k++) begin
            checkOutput($sformatf("lat_rotate_%0d", k), rotate, k == 1);
            checkOutput($sformatf("lat_start_%0d", k), path_start, k == 2 + SETTLE);
            checkOutput($sformatf("lat_cvalid_%0d", k), cipher_valid, k == 4 + SETTLE);
            if (k == 2 + SETTLE) checkOutput("lat_path_char", path_char, 0);
            if (k == 4 + SETTLE) checkOutput("lat_cipher_N", cipher_char, 13);
            tick();
        end
        checkOutput("lat_count", char_count, 1);

        // Three back-to-back keys with key_valid held high. key_char changes
        // while key_ready is low.
        e0 = rotEdges;
        key_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            key_char = 5'(3 + 7 * n);
            waitKeyReady("tmo_b2b_ready");
            expQ.push_back(encodeRef(key_char));
            tick();
            key_char = 5'd31;
        end
        key_valid = 1'b0;
        waitCount("b2b_count", 4);
        checkOutput("b2b_rot_edges", rotEdges - e0, 3);

        // Consumer stalls for 5 cycles in OUT.
        cipher_ready = 1'b0;
        applyStimulus(5'd25, 1);
        for (int n = 0; n < 20 && !cipher_valid; n++) tick();
        for (int n = 0; n < 5; n++) begin
            checkOutput("stall_cvalid", cipher_valid, 1);
            checkOutput("stall_cchar", cipher_char, encodeRef(5'd25));
            checkOutput("stall_key_ready", key_ready, 0);
            tick();
        end
        checkOutput("stall_count_hold", char_count, 4);
        cipher_ready = 1'b1;
        tick();
        checkOutput("stall_count_inc", char_count, 5);
        checkOutput("stall_cvalid_low", cipher_valid, 0);
        tick();
        tick();
        checkOutput("stall_count_once", char_count, 5);

        // config_mode blocks new keys while the sequencer is idle.
        e0 = rotEdges;
        config_mode = 1'b1;
        key_valid   = 1'b1;
        key_char    = 5'd4;
        tick();
        checkOutput("cfg_key_ready", key_ready, 0);
        tick();
        tick();
        checkOutput("cfg_no_rotate", rotEdges - e0, 0);
        checkOutput("cfg_busy", busy, 0);
        key_valid   = 1'b0;
        config_mode = 1'b0;

        // config_mode raised during SETTLE: the current letter still completes.
        applyStimulus(5'd7, 1);
        tick();
        config_mode = 1'b1;
        waitCount("cfg_mid_count", 6);
        tick();
        checkOutput("cfg_mid_key_ready", key_ready, 0);
        config_mode = 1'b0;

        // Reset in WAIT. The stray path_valid that arrives later is ignored.
        respEn = 0;
        applyStimulus(5'd9, 1);
        for (int n = 0; n < 20 && !path_start; n++) tick();
        checkOutput("wait_path_start", path_start, 1);
        tick();
        checkOutput("wait_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expQ.delete();
        checkOutput("wrst_busy", busy, 0);
        checkOutput("wrst_cvalid", cipher_valid, 0);
        checkOutput("wrst_rotate", rotate, 0);
        checkOutput("wrst_count", char_count, 0);
        manualPv = 1;
        tick();
        manualPv = 0;
        tick();
        checkOutput("late_pv_busy", busy, 0);
        checkOutput("late_pv_cvalid", cipher_valid, 0);
        respEn = 1;

        // Out-of-range letter 27.
        e0 = rotEdges;
`ifdef KEY_RANGE_CHECK_EN
        applyStimulus(5'd27, 0);
        checkOutput("rng_rotate", rotate, 0);
        checkOutput("rng_busy", busy, 0);
        checkOutput("rng_err", range_err, 1);
        for (int n = 0; n < 4; n++) tick();
        checkOutput("rng_err_sticky", range_err, 1);
        checkOutput("rng_count", char_count, 0);
        checkOutput("rng_no_edge", rotEdges - e0, 0);
`else
        applyStimulus(5'd27, 1);
        waitCount("rng_count", 1);
        checkOutput("rng_edge", rotEdges - e0, 1);
        checkOutput("rng_err_zero", range_err, 0);
`endif
        tick();
        tick();
        checkOutput("sb_drained", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
